// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin scheduler sharing one 5x5 signed Baugh-Wooley
// multiplier among four valid/ready requesters, with one response handshake.
// Build option: define MULT_ARB_BYPASS_EN to drop the EXEC stage and the
// operand registers (multiplier fed straight from the winning request).

// 5x5 signed multiplier, 10-bit two's-complement product (combinational)
module mult (
    input  logic [4:0] i_d1,
    input  logic [4:0] i_d2,
    output logic [9:0] o_p
);
    logic [9:0] w_acc;
    logic       w_pp;

    // Baugh-Wooley: plain partial products, complemented sign-row/column
    // terms, and the 2^5 + 2^9 correction constant (modulo 2^10)
    always_comb begin
        w_pp  = 1'b0;
        w_acc = 10'h220;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_pp  = i_d1[i] & i_d2[j];
                w_acc = w_acc + ({9'd0, w_pp} << (i + j));
            end
        end
        w_pp  = i_d1[4] & i_d2[4];
        w_acc = w_acc + ({9'd0, w_pp} << 8);
        for (int j = 0; j < 4; j++) begin
            w_pp  = ~(i_d1[4] & i_d2[j]);
            w_acc = w_acc + ({9'd0, w_pp} << (4 + j));
        end
        for (int i = 0; i < 4; i++) begin
            w_pp  = ~(i_d1[i] & i_d2[4]);
            w_acc = w_acc + ({9'd0, w_pp} << (4 + i));
        end
        o_p = w_acc;
    end
endmodule

module mult_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [19:0] req_a,
    input  logic [19:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [9:0]  rsp_data,
    output logic [1:0]  rsp_id,
    output logic        busy
);
    localparam int NREQ = 4;
    localparam int W    = 5;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

    state_t       r_state, w_next;
    logic [1:0]   r_last, r_id;
    logic [1:0]   w_winner, w_idx;
    logic         w_found, w_grant;
    logic [W-1:0] w_sel_a, w_sel_b, w_m_a, w_m_b;
    logic [9:0]   w_prod, r_res;
`ifndef MULT_ARB_BYPASS_EN
    logic [W-1:0] r_op_a, r_op_b;
`endif

    // Rotating-priority search: first valid requester after the last grant
    always_comb begin
        w_found  = 1'b0;
        w_winner = 2'd0;
        w_idx    = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_found;
    assign w_sel_a = req_a[w_winner*W +: W];
    assign w_sel_b = req_b[w_winner*W +: W];

`ifdef MULT_ARB_BYPASS_EN
    assign w_m_a = w_sel_a;
    assign w_m_b = w_sel_b;
`else
    assign w_m_a = r_op_a;
    assign w_m_b = r_op_b;
`endif

    mult u_mult (
        .i_d1 (w_m_a),
        .i_d2 (w_m_b),
        .o_p  (w_prod)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: grant leaves IDLE, response handshake returns to it
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef MULT_ARB_BYPASS_EN
                if (w_found) w_next = S_RESP;
`else
                if (w_found) w_next = S_EXEC;
`endif
            end
`ifndef MULT_ARB_BYPASS_EN
            S_EXEC: w_next = S_RESP;
`endif
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: ready only to the IDLE winner, response valid only in RESP
    always_comb begin
        req_ready = w_grant ? (4'b0001 << w_winner) : 4'b0000;
        rsp_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE);
    end

    // Datapath: capture winner/operands on grant, product into res_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 2'd3;
            r_id   <= 2'd0;
            r_res  <= 10'd0;
`ifndef MULT_ARB_BYPASS_EN
            r_op_a <= '0;
            r_op_b <= '0;
`endif
        end else begin
            if (w_grant) begin
                r_last <= w_winner;
                r_id   <= w_winner;
`ifdef MULT_ARB_BYPASS_EN
                r_res  <= w_prod;
`else
                r_op_a <= w_sel_a;
                r_op_b <= w_sel_b;
`endif
            end
`ifndef MULT_ARB_BYPASS_EN
            if (r_state == S_EXEC) r_res <= w_prod;
`endif
        end
    end

    assign rsp_data = r_res;
    assign rsp_id   = r_id;
endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin / product model.
module tb_mult_arbiter;
`ifdef MULT_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [19:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [9:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mult_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] ref_prod(input logic [4:0] a, input logic [4:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[9:0];
    endfunction

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        step();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 10'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 000", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        step();
        rst = 1'b0;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_first_pri got %b exp 0010", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_a[14:10] = 5'd7; req_b[14:10] = 5'b11101; req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_drop c=%0d got %b exp 0000", c, req_ready); end
            checks++; if (rsp_valid !== (c == LAT)) begin errors++; $display("FAIL single_latency c=%0d got %b exp %b", c, rsp_valid, c == LAT); end
            if (c < LAT) step();
        end
        checks++; if (rsp_data !== 10'h3EB) begin errors++; $display("FAIL single_data got %h exp 3eb", rsp_data); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d exp 2", rsp_id); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_retire got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_corners();
        logic [4:0] ca[4];
        logic [4:0] cb[4];
        logic [9:0] ce[4];
        int id;
        bit seen;
        ca = '{5'h10, 5'h10, 5'h00, 5'h0F};
        cb = '{5'h10, 5'h0F, 5'h10, 5'h0F};
        ce = '{10'h100, 10'h310, 10'h000, 10'h0E1};
        do_reset();
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            id = int'($urandom_range(0, 3));
            req_a = '0; req_b = '0;
            req_a[id*5 +: 5] = ca[t]; req_b[id*5 +: 5] = cb[t];
            req_valid = 4'b0001 << id;
            seen = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(negedge clk);
                if (req_ready != 4'b0) seen = 1; else step();
            end
            checks++; if (req_ready !== (4'b0001 << id)) begin errors++; $display("FAIL corner%0d_grant got %b exp %b", t, req_ready, 4'b0001 << id); end
            step();
            req_valid = '0;
            seen = 0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1; else step();
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL corner%0d_timeout got no rsp_valid exp rsp_valid", t); end
            else begin
                if (rsp_data !== ce[t]) begin errors++; $display("FAIL corner%0d_data got %h exp %h", t, rsp_data, ce[t]); end
                checks++; if (rsp_data !== ref_prod(ca[t], cb[t])) begin errors++; $display("FAIL corner%0d_model got %h exp %h", t, rsp_data, ref_prod(ca[t], cb[t])); end
                checks++; if (rsp_id !== 2'(id)) begin errors++; $display("FAIL corner%0d_id got %0d exp %0d", t, rsp_id, id); end
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] a[4];
        logic [4:0] b[4];
        int gcyc[$];
        int gid[$];
        int rid[$];
        logic [9:0] rdat[$];
        int idx;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 5'($urandom); b[i] = 5'($urandom);
            req_a[i*5 +: 5] = a[i]; req_b[i*5 +: 5] = b[i];
        end
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 40 && gcyc.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (req_ready == (4'b0001 << i)) idx = i;
                gcyc.push_back(c); gid.push_back(idx);
            end
            if (rsp_valid) begin rid.push_back(int'(rsp_id)); rdat.push_back(rsp_data); end
            step();
        end
        req_valid = '0;
        checks++; if (gcyc.size() != 5) begin errors++; $display("FAIL rr_grant_count got %0d exp 5", gcyc.size()); end
        for (int g = 0; g < gcyc.size(); g++) begin
            checks++; if (gid[g] != g % 4) begin errors++; $display("FAIL rr_order g=%0d got %0d exp %0d", g, gid[g], g % 4); end
            if (g > 0) begin
                checks++; if (gcyc[g] - gcyc[g-1] != LAT + 1) begin errors++; $display("FAIL rr_spacing g=%0d got %0d exp %0d", g, gcyc[g] - gcyc[g-1], LAT + 1); end
            end
        end
        checks++; if (rid.size() < 4) begin errors++; $display("FAIL rr_rsp_count got %0d exp >=4", rid.size()); end
        for (int r = 0; r < rid.size(); r++) begin
            checks++;
            if (rid[r] != r % 4 || rdat[r] !== ref_prod(a[r%4], b[r%4])) begin
                errors++; $display("FAIL rr_rsp r=%0d got id=%0d data=%h exp id=%0d data=%h", r, rid[r], rdat[r], r % 4, ref_prod(a[r%4], b[r%4]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] a, b;
        bit seen;
        do_reset();
        a = 5'($urandom); b = 5'($urandom);
        req_a[9:5] = a; req_b[9:5] = b; req_valid = 4'b0010; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
        step();
        req_valid = 4'b1000;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1; else step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got no rsp_valid exp rsp_valid"); end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ref_prod(a, b) || rsp_id !== 2'd1 || req_ready !== 4'b0) begin
                errors++; $display("FAIL bp_stall c=%0d got v=%b d=%h id=%0d rdy=%b exp v=1 d=%h id=1 rdy=0000", c, rsp_valid, rsp_data, rsp_id, req_ready, ref_prod(a, b));
            end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_last got %b exp 1", rsp_valid); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin errors++; $display("FAIL bp_retire got v=%b rdy=%b exp v=0 rdy=1000", rsp_valid, req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a[14:10] = 5'd9; req_b[14:10] = 5'd3; req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 10'h0 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
            errors++; $display("FAIL rmid_async got busy=%b v=%b d=%h id=%0d rdy=%b exp all 0", busy, rsp_valid, rsp_data, rsp_id, req_ready);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp c=%0d got %b exp 0", c, rsp_valid); end
            step();
        end
        req_valid = 4'hF;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_random();
        int m_last, k, w, p_id;
        bit outst, g_now, r_now, exp_v;
        logic [3:0] exp_rdy;
        logic [9:0] p_prod;
        do_reset();
        m_last = 3; outst = 0; k = 0; p_id = 0; p_prod = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            w = rr_pick(m_last, req_valid);
            g_now = !outst && (w >= 0);
            exp_rdy = g_now ? (4'b0001 << w) : 4'b0000;
            exp_v = outst && (k >= LAT);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rand_valid c=%0d got %b exp %b", c, rsp_valid, exp_v); end
            checks++; if (busy !== outst) begin errors++; $display("FAIL rand_busy c=%0d got %b exp %b", c, busy, outst); end
            if (exp_v) begin
                checks++;
                if (rsp_data !== p_prod || rsp_id !== 2'(p_id)) begin
                    errors++; $display("FAIL rand_rsp c=%0d got d=%h id=%0d exp d=%h id=%0d", c, rsp_data, rsp_id, p_prod, p_id);
                end
            end
            r_now = exp_v && rsp_ready;
            if (g_now) begin p_id = w; p_prod = ref_prod(req_a[w*5 +: 5], req_b[w*5 +: 5]); end
            step();
            if (r_now) outst = 0;
            else if (outst) k++;
            if (g_now) begin outst = 1; k = 1; m_last = w; end
            for (int i = 0; i < 4; i++) begin
                if ((g_now && i == w) || !req_valid[i]) begin
                    if (($urandom % 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_a[i*5 +: 5] = 5'($urandom);
                        req_b[i*5 +: 5] = 5'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_corners();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler sharing one 5x5 signed (two's-complement, Baugh-Wooley) `mult` instance among four requesters. Accepts operand pairs over per-requester valid/ready handshakes, registers the granted operands into the multiplier and returns the registered 10-bit product with the winner's ID over a single response handshake. Sits between the request-generating blocks and the shared multiplier datapath.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4, so the ID field is 2 bits.
- `W`, 5: operand width; fixed by `mult` and not overridable.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  4  bit i: requester i holds a valid operand pair.
- `req_ready`  out  4  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  in  20  requester i's D1 operand is `req_a[5i+4:5i]`, signed.
- `req_b`  in  20  requester i's D2 operand is `req_b[5i+4:5i]`, signed.
- `rsp_valid`  out  1  response holds a valid product.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  10  signed product from `mult`.
- `rsp_id`  out  2  index of the requester that owns `rsp_data`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, pick the winner by round-robin. The search starts at `last+1` mod 4, where `last` is the index of the previous grant.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - On that clock edge: capture the winner's operands into `op_a`/`op_b`, capture the winner into `id_q`, set `last` to the winner, and go to EXEC.
- EXEC:
  - `op_a`/`op_b` drive `mult` D1/D2.
  - On the edge, register the `mult` output into `res_q` and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data`=`res_q`; `rsp_id`=`id_q`.
  - Hold these until `rsp_valid && rsp_ready`, then go to IDLE.
  - `rsp_data` and `rsp_id` must stay stable while stalled.
- `req_ready` is 0 in EXEC and RESP. No new grant is issued until the response retires.
- `req_valid` must not depend on `req_ready`. A requester holds its valid and operands until it sees `req_ready`.
- Arithmetic is full-precision 5x5 signed to 10-bit signed. No overflow is possible; the range is -240..+256.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - `op_a`=`op_b`=0, `res_q`=0.
  - `last`=3, so requester 0 has the highest priority after reset.
- Latency: a grant at edge N gives `rsp_valid` high after edge N+2.
- Peak throughput: one product per 3 cycles when `rsp_ready` is held high. The response handshake in RESP returns to IDLE, and the next grant happens in the following cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. The losers keep `req_valid` high and are served in rotating order, so each is guaranteed service within 4 grants.
- A requester that drops `req_valid` without seeing `req_ready` is simply not granted. This is legal, but the requester is responsible for any operand it loses that way.
- `rsp_ready` seen outside RESP is ignored.
- `rst` asserted mid-operation (EXEC or RESP) immediately returns all state to the reset values. The in-flight product is discarded and no response is emitted for it.

## Configuration
- `MULT_ARB_BYPASS_EN`
- Defined:
  - The EXEC state and the `op_a`/`op_b` registers are removed.
  - In IDLE, `mult` is driven combinationally by the winner's `req_a`/`req_b` slices.
  - `res_q` and `id_q` load on the grant edge and the FSM goes directly to RESP.
  - Latency is 1 cycle (grant at edge N, `rsp_valid` after edge N+1); peak throughput is one product per 2 cycles.
- Undefined: the registered 3-state behaviour described above.
- Round-robin policy, handshake rules and reset values are identical in both builds.

## Test plan
- Reset, then a single request from requester 2 with a=7, b=-3:
  - `req_ready`=4'b0100 for one cycle.
  - `rsp_valid` high 2 cycles later with `rsp_data`=10'h3EB and `rsp_id`=2.
- Corner operands:
  - -16*-16 gives 10'h100.
  - -16*15 gives 10'h310.
  - 0*-16 gives 10'h000.
  - 15*15 gives 10'h0E1.
- All four `req_valid` held high from reset with `rsp_ready`=1:
  - Grants in order 0,1,2,3,0.
  - `rsp_id` follows the same sequence.
  - Successive grants are spaced 3 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while in RESP.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay stable.
  - `req_ready` stays 0 throughout.
  - Retirement happens in the cycle `rsp_ready` rises.
- Assert `rst` for 1 cycle while in EXEC:
  - All outputs return to 0 immediately.
  - No response is produced for the discarded product.
  - The next request from requester 0 is granted first.
- `MULT_ARB_BYPASS_EN` build: repeat the single-request test.
  - `rsp_valid` rises 1 cycle after the grant.
  - The four-requester round-robin test shows successive grants 2 cycles apart.
